l0_skew_fifo_bank: RTL and testbench
====================================

Name: l0_skew_fifo_bank

Overview:
Parametrised L0 input buffer bank for the systolic array: ROW independent FIFOs, each BW bits wide and DEPTH entries deep.
- All rows are written in parallel from one packed input word.
- Reads are either aligned (all rows pop together) or skewed: row r pops r cycles after row 0. This skewed mode produces the diagonal wavefront the PE array needs.
- Sits between the activation/weight SRAM and the array's west (or north) edge.

Parameters:
ROW, 8, number of row channels (>=1)
BW, 4, data width per row in bits
DEPTH, 64, entries per row FIFO; power of 2, >=2

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in  input  ROW*BW  write data; row r = in[r*BW +: BW]
wr  input  1  write request, all rows
rd  input  1  read request (level)
i_skew_mode  input  1  0 = aligned read, 1 = skewed read
out  output  ROW*BW  registered read data; row r = out[r*BW +: BW]
o_valid  output  ROW  per-row: out row updated by a pop last cycle
o_full  output  1  any row FIFO full
o_ready  output  1  = !o_full; a write is accepted this cycle
o_empty  output  1  all row FIFOs empty
o_err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all pointers 0, out=0, o_valid=0, rd delay line=0, o_full=0, o_ready=1, o_empty=1, o_err=0. Reset mid-operation discards all contents immediately.
- Storage: per-row circular buffer.
  - Read/write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Wrap-around is natural modulo 2*DEPTH.
- Write:
  - Accepted when wr=1 and o_ready=1.
  - Writes row r's slice to every row FIFO in the same cycle; all write pointers advance together.
  - wr while o_full=1 is dropped; no state changes.
- Row read enable:
  - rd_dly[0]=rd.
  - rd_dly[r] is a register of rd_dly[r-1]; the delay line shifts every cycle regardless of mode.
  - pop[r] = (i_skew_mode ? rd_dly[r] : rd) && !empty[r].
- Pop:
  - The head entry is registered into out row r at the clock edge; read pointer r advances.
  - o_valid[r]=1 in the following cycle, so data latency from the sampled rd is 1 cycle for row 0 and r+1 cycles for row r in skew mode.
  - With no pop, out row r holds its value and o_valid[r]=0.
- Empty row read: ignored (pointer and out unchanged, o_valid[r]=0). There is no write-to-read bypass; a row empty at the edge cannot pop the word being written that edge.
- Simultaneous wr and pop on the same row:
  - Both occur if legal.
  - The full check uses the pre-edge state, so a write to a full row is rejected even if that row pops the same cycle.
- Status outputs:
  - o_full = OR of per-row full.
  - o_empty = AND of per-row empty.
  - Both are derived combinationally from the registered pointers.
- Mode change: i_skew_mode takes effect the same cycle it changes. Changing it while rd_dly is non-zero is legal; rows follow the formula above.

Optional Feature:
Macro L0_ERR_FLAG_EN.
- Defined: o_err is set and held sticky (cleared only by reset) on either of:
  - wr=1 while o_full=1;
  - any row whose selected read request is 1 while that row is empty.
- Undefined: o_err is tied 0 and no error logic is synthesised.

Test Plan:
1. Reset, then wr=1 for 4 cycles with in=32'h76543210, 32'hFEDCBA98, 32'h0, 32'h11111111 -> o_empty falls after the first edge; o_full=0 throughout.
2. After 1, aligned mode, rd=1 for 4 cycles -> out is 32'h76543210, FEDCBA98, 0, 11111111 on consecutive cycles, each one cycle after rd; o_valid=8'hFF; o_empty=1 afterwards.
3. Write one word 32'h76543210, skew mode, rd=1 for 8 cycles -> o_valid goes 8'h01, 02, 04 ... 80 on successive cycles; row r nibble = r when its bit is set.
4. 64 writes of incrementing data -> o_full=1, o_ready=0 after the 64th; a 65th write is ignored; 64 aligned reads return 0..63 in order with no loss across the pointer wrap.
5. rd=1 while empty -> o_valid=0, out holds its previous value; with L0_ERR_FLAG_EN, o_err=1 and stays 1 until reset.
6. Assert reset during a skewed read of a half-full bank -> all outputs take reset values asynchronously; after release, o_empty=1 and o_ready=1.

Source files
------------

// File: rtl/l0_skew_fifo_bank.sv
// ============================================================================
// Module  : l0_skew_fifo_bank
// Brief   : ROW parallel-write FIFOs with aligned or skewed (diagonal) reads
//           feeding one edge of the systolic array. Optional sticky error flag
//           enabled by defining L0_ERR_FLAG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module l0_skew_fifo_bank #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROW*BW-1:0] in,
    input  logic              wr,
    input  logic              rd,
    input  logic              i_skew_mode,
    output logic [ROW*BW-1:0] out,
    output logic [ROW-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty,
    output logic              o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  wr_ptr_d;
    logic [ROW-1:0] row_empty;
    logic [ROW-1:0] row_full;
    logic [ROW-1:0] row_sel;
    logic [ROW-1:0] row_pop;
    logic [ROW-1:0] rd_dly;
    logic           full_any;
    logic           wr_en;

    assign full_any = |row_full;
    assign wr_en    = wr && !full_any;
    assign o_full   = full_any;
    assign o_ready  = !full_any;
    assign o_empty  = &row_empty;
    assign wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;

    // Every row is written together, so a single write pointer serves all rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    generate
        if (ROW > 1) begin : g_dly
            logic [ROW-2:0] dly_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= rd_dly[ROW-2:0];
                end
            end
            assign rd_dly = {dly_q, rd};
        end else begin : g_nodly
            assign rd_dly = rd;
        end
    endgenerate

    generate
        for (genvar r = 0; r < ROW; r++) begin : g_row
            logic [BW-1:0] mem_q [DEPTH];
            logic [PW-1:0] rd_ptr_q;
            logic [PW-1:0] rd_ptr_d;
            logic [BW-1:0] dout_q;
            logic          vld_q;

            assign row_empty[r] = (rd_ptr_q == wr_ptr_q);
            assign row_full[r]  = (rd_ptr_q == {~wr_ptr_q[AW], wr_ptr_q[AW-1:0]});
            assign row_sel[r]   = i_skew_mode ? rd_dly[r] : rd;
            assign row_pop[r]   = row_sel[r] && !row_empty[r];
            assign rd_ptr_d     = row_pop[r] ? rd_ptr_q + PW'(1) : rd_ptr_q;

            // Storage is not reset; the pointers alone define valid contents.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= in[r*BW +: BW];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_ptr_q <= '0;
                    dout_q   <= '0;
                    vld_q    <= 1'b0;
                end else begin
                    rd_ptr_q <= rd_ptr_d;
                    vld_q    <= row_pop[r];
                    if (row_pop[r]) begin
                        dout_q <= mem_q[rd_ptr_q[AW-1:0]];
                    end
                end
            end

            assign out[r*BW +: BW] = dout_q;
            assign o_valid[r]      = vld_q;
        end
    endgenerate

`ifdef L0_ERR_FLAG_EN
    logic err_q;

    // Overflowing write or a selected read of an empty row latches the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((wr && full_any) || |(row_sel & row_empty)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l0_skew_fifo_bank.sv
// ============================================================================
// Module  : tb_l0_skew_fifo_bank
// Brief   : Directed self-checking bench for l0_skew_fifo_bank (defaults).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l0_skew_fifo_bank;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
`ifdef L0_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [ROW*BW-1:0] in;
    logic              wr;
    logic              rd;
    logic              i_skew_mode;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic              o_err;

    int vecs;
    int miss;
    logic [31:0] data_tbl [DEPTH];

    l0_skew_fifo_bank #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .i_skew_mode (i_skew_mode),
        .out         (out),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_empty     (o_empty),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},   64'(out),     64'h0);
        chk({tag, "_valid"}, 64'(o_valid), 64'h0);
        chk({tag, "_full"},  64'(o_full),  64'h0);
        chk({tag, "_ready"}, 64'(o_ready), 64'h1);
        chk({tag, "_empty"}, 64'(o_empty), 64'h1);
        chk({tag, "_err"},   64'(o_err),   64'h0);
    endtask

    initial begin
        logic [31:0] t1 [4];
        vecs = 0;
        miss = 0;
        t1[0] = 32'h76543210;
        t1[1] = 32'hFEDCBA98;
        t1[2] = 32'h00000000;
        t1[3] = 32'h11111111;
        for (int i = 0; i < DEPTH; i++) data_tbl[i] = 32'h9E3779B9 * 32'(i + 1);

        reset = 1'b1; wr = 1'b0; rd = 1'b0; i_skew_mode = 1'b0; in = '0;
        #12;
        chk_reset_vals("reset");
        reset = 1'b0;

        // Fill four words
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = t1[i];
            tick();
            chk("t1_empty", 64'(o_empty), 64'h0);
            chk("t1_full",  64'(o_full),  64'h0);
        end
        wr = 1'b0;

        // Aligned drain
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_out",   64'(out),     64'(t1[i]));
            chk("t2_valid", 64'(o_valid), 64'hFF);
        end
        rd = 1'b0;
        chk("t2_empty", 64'(o_empty), 64'h1);
        chk("t2_err",   64'(o_err),   64'h0);
        tick();
        chk("t2_idle_valid", 64'(o_valid), 64'h0);
        chk("t2_idle_out",   64'(out),     64'h11111111);
        for (int i = 0; i < 8; i++) tick();

        // Skewed wavefront of one word
        wr = 1'b1; in = 32'h76543210;
        tick();
        wr = 1'b0; i_skew_mode = 1'b1; rd = 1'b1;
        for (int k = 0; k < ROW; k++) begin
            logic [3:0] nib;
            tick();
            nib = out[k*BW +: BW];
            chk("t3_valid", 64'(o_valid), 64'(8'h01 << k));
            chk("t3_nib",   64'(nib),     64'(k));
        end
        rd = 1'b0;
        chk("t3_empty", 64'(o_empty), 64'h1);
        for (int i = 0; i < 8; i++) tick();
        i_skew_mode = 1'b0;

        // Fill to full across the pointer wrap, then drain
        wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_prefull", 64'(o_full), 64'h0);
            in = data_tbl[i];
            tick();
        end
        chk("t4_full",  64'(o_full),  64'h1);
        chk("t4_ready", 64'(o_ready), 64'h0);
        in = 32'hDEADBEEF;
        tick();
        wr = 1'b0;
        chk("t4_full_hold", 64'(o_full), 64'h1);
        rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("t4_out",   64'(out),     64'(data_tbl[i]));
            chk("t4_valid", 64'(o_valid), 64'hFF);
        end
        chk("t4_empty", 64'(o_empty), 64'h1);

        // Read while empty
        tick();
        chk("t5_valid", 64'(o_valid), 64'h0);
        chk("t5_out",   64'(out),     64'(data_tbl[DEPTH-1]));
        chk("t5_err",   64'(o_err),   64'(ERR_EN));
        rd = 1'b0;
        tick();
        chk("t5_err_sticky", 64'(o_err), 64'(ERR_EN));

        // Async reset during skewed read of a half-full bank
        wr = 1'b1;
        for (int i = 0; i < DEPTH/2; i++) begin
            in = data_tbl[i];
            tick();
        end
        wr = 1'b0; i_skew_mode = 1'b1; rd = 1'b1;
        tick(); tick(); tick();
        chk("t6_pre_valid", 64'(o_valid), 64'h07);
        #3 reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        #2 reset = 1'b0; rd = 1'b0;
        tick();
        chk("t6_empty", 64'(o_empty), 64'h1);
        chk("t6_ready", 64'(o_ready), 64'h1);
        chk("t6_valid", 64'(o_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
